// File: rtl/axi_wr_split.sv
`default_nettype none
//------------------------------------------------------------------------------
// axi_wr_split : splits AXI write bursts into sub-bursts of at most MAX_LEN+1
//                beats and merges their write responses back into one.
// Revision     : 1.0
//------------------------------------------------------------------------------

module axi_wr_split_fifo #(
  parameter int WIDTH = 8,
  parameter int LD    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [LD:0]      count
);
  logic [WIDTH-1:0] mem [2**LD];
  logic [LD-1:0]    wr_ptr;
  logic [LD-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LD'(1);
      if (pop)  rd_ptr <= rd_ptr + LD'(1);
      count <= count + (LD+1)'(push) - (LD+1)'(pop);
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
endmodule

module axi_wr_split #(
  parameter int MAX_LEN = 15,
  parameter int FIFO_LD = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  s_awid,
  input  logic [63:0]  s_awaddr,
  input  logic [7:0]   s_awlen,
  input  logic [2:0]   s_awsize,
  input  logic         s_awvalid,
  output logic         s_awready,
  input  logic [511:0] s_wdata,
  input  logic [63:0]  s_wstrb,
  input  logic         s_wlast,
  input  logic         s_wvalid,
  output logic         s_wready,
  output logic [15:0]  s_bid,
  output logic [1:0]   s_bresp,
  output logic         s_bvalid,
  input  logic         s_bready,
  output logic [15:0]  m_awid,
  output logic [63:0]  m_awaddr,
  output logic [7:0]   m_awlen,
  output logic [2:0]   m_awsize,
  output logic         m_awvalid,
  input  logic         m_awready,
  output logic [511:0] m_wdata,
  output logic [63:0]  m_wstrb,
  output logic         m_wlast,
  output logic         m_wvalid,
  input  logic         m_wready,
  input  logic [15:0]  m_bid,
  input  logic [1:0]   m_bresp,
  input  logic         m_bvalid,
  output logic         m_bready
);
  localparam logic [FIFO_LD:0] DEPTH     = (FIFO_LD+1)'(2**FIFO_LD);
  localparam logic [8:0]       SUB_BEATS = 9'(MAX_LEN + 1);
  localparam logic [7:0]       MAX_AWLEN = 8'(MAX_LEN);

  typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  state_t       state;
  logic [8:0]   rest;
  logic [7:0]   beat_cnt;
  logic [7:0]   sub_cnt;
  logic [1:0]   resp_acc;

  logic         s_aw_hs, m_aw_hs, w_hs, b_hs;
  logic [7:0]   first_len, next_len, nsub_m1;
  logic [8:0]   rest_m1;
  logic [63:0]  next_addr;

  logic         wlf_pop, wlf_empty, wlf_room_nxt;
  logic [7:0]   wlf_head;
  logic [FIFO_LD:0] wlf_count, wlf_cnt_nxt;

  logic         btf_pop, btf_empty, btf_full, b_final;
  logic [23:0]  btf_head;
  logic [FIFO_LD:0] btf_count;
  logic [1:0]   merged_resp;

  logic         unused_inputs;
  assign unused_inputs = ^{m_bid, s_wlast};

  // ---------------- AW path ----------------
  assign s_awready = (state == IDLE) && !btf_full;
  assign s_aw_hs   = s_awvalid && s_awready;
  assign m_aw_hs   = m_awvalid && m_awready;

  assign first_len = (s_awlen > MAX_AWLEN) ? MAX_AWLEN : s_awlen;
  assign nsub_m1   = 8'({1'b0, s_awlen} / SUB_BEATS);
  assign rest_m1   = rest - 9'd1;
  assign next_len  = (rest_m1 > {1'b0, MAX_AWLEN}) ? MAX_AWLEN : rest_m1[7:0];
  assign next_addr = m_awaddr + (({56'd0, m_awlen} + 64'd1) << m_awsize);

  // Only valid once the length FIFO is guaranteed room for the push on handshake.
  assign wlf_cnt_nxt  = wlf_count + (FIFO_LD+1)'(m_aw_hs) - (FIFO_LD+1)'(wlf_pop);
  assign wlf_room_nxt = (wlf_cnt_nxt != DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      m_awlen   <= '0;
      m_awid    <= '0;
      m_awsize  <= '0;
      rest      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_aw_hs) begin
            m_awaddr  <= s_awaddr;
            m_awlen   <= first_len;
            m_awid    <= s_awid;
            m_awsize  <= s_awsize;
            rest      <= {1'b0, s_awlen} - {1'b0, first_len};
            m_awvalid <= wlf_room_nxt;
            state     <= SPLIT;
          end
        end
        SPLIT: begin
          if (m_aw_hs) begin
            if (rest == 9'd0) begin
              m_awvalid <= 1'b0;
              state     <= IDLE;
            end else begin
              m_awaddr  <= next_addr;
              m_awlen   <= next_len;
              rest      <= rest - {1'b0, next_len} - 9'd1;
              m_awvalid <= wlf_room_nxt;
            end
          end else if (!m_awvalid) begin
            m_awvalid <= wlf_room_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- W path ----------------
  axi_wr_split_fifo #(.WIDTH(8), .LD(FIFO_LD)) u_wlf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (m_aw_hs),
    .din   (m_awlen),
    .pop   (wlf_pop),
    .dout  (wlf_head),
    .count (wlf_count)
  );

  assign wlf_empty = (wlf_count == '0);
  assign m_wdata   = s_wdata;
  assign m_wstrb   = s_wstrb;
  assign m_wvalid  = s_wvalid && !wlf_empty;
  assign s_wready  = m_wready && !wlf_empty;
  assign m_wlast   = !wlf_empty && (beat_cnt == wlf_head);
  assign w_hs      = m_wvalid && m_wready;
  assign wlf_pop   = w_hs && m_wlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (w_hs) begin
      beat_cnt <= m_wlast ? 8'd0 : beat_cnt + 8'd1;
    end
  end

  // ---------------- B path ----------------
  axi_wr_split_fifo #(.WIDTH(24), .LD(FIFO_LD)) u_btf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_aw_hs),
    .din   ({s_awid, nsub_m1}),
    .pop   (btf_pop),
    .dout  (btf_head),
    .count (btf_count)
  );

  assign btf_empty   = (btf_count == '0);
  assign btf_full    = (btf_count == DEPTH);
  assign b_final     = (sub_cnt == btf_head[7:0]);
  assign merged_resp = (m_bresp > resp_acc) ? m_bresp : resp_acc;

  // Intermediate responses are absorbed; only the last one reaches the slave.
  assign m_bready = !btf_empty && (!b_final || s_bready);
  assign s_bvalid = !btf_empty && b_final && m_bvalid;
  assign s_bid    = btf_head[23:8];
  assign s_bresp  = merged_resp;
  assign b_hs     = m_bvalid && m_bready;
  assign btf_pop  = b_hs && b_final;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt  <= '0;
      resp_acc <= '0;
    end else if (b_hs) begin
      if (b_final) begin
        sub_cnt  <= '0;
        resp_acc <= '0;
      end else begin
        sub_cnt  <= sub_cnt + 8'd1;
        resp_acc <= merged_resp;
      end
    end
  end
endmodule
`default_nettype wire
